// File: rtl/seg_scan_reader.sv
// Read-back of a multiplexed active-low 7-segment bus: qualifies each digit for
// stability, decodes it to a hex nibble and presents whole frames on valid/ready.
module seg_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [6:0]            iSeg,
    input  logic [DIGITS-1:0]     iAn,
    input  logic                  iReady,
    output logic                  oFrameValid,
    output logic [4*DIGITS-1:0]   oDigits,
    output logic [DIGITS-1:0]     oBlank,
    output logic [DIGITS-1:0]     oErr,
    output logic                  oOverrun
);

    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

    state_t              state, state_next;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic [DIGITS-1:0]   prev_an;
    logic [6:0]          ref_seg, ref_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [7:0]          cnt, cnt_next;
    logic [DIGITS-1:0]   seen, seen_next;
    logic [4*DIGITS-1:0] work_digits;
    logic [DIGITS-1:0]   work_blank;
    logic [DIGITS-1:0]   work_err;

    logic                single;
    logic [IDX_W-1:0]    an_idx;
    logic [3:0]          zero_cnt;
    logic                capture;
    logic                frame_done;
    logic                load;
    logic                drop;
    logic                transfer;
    logic [5:0]          dec;

    // Returns {blank, err, nibble}; 1100000 is shared by the driver's 6 and B glyphs and reads as 6.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b000000;
        case (seg)
            7'b0000001: r = 6'h00;
            7'b1001111: r = 6'h01;
            7'b0010010: r = 6'h02;
            7'b0000110: r = 6'h03;
            7'b1001100: r = 6'h04;
            7'b0100100: r = 6'h05;
            7'b1100000: r = 6'h06;
            7'b0100000: r = 6'h06;
            7'b0001111: r = 6'h07;
            7'b0000000: r = 6'h08;
            7'b0001100: r = 6'h09;
            7'b0001000: r = 6'h0A;
            7'b0110001: r = 6'h0C;
            7'b1000010: r = 6'h0D;
            7'b0110000: r = 6'h0E;
            7'b0111000: r = 6'h0F;
            7'b1111111: r = 6'b100000;
            default:    r = 6'b010000;
        endcase
        return r;
    endfunction

    assign dec = decode(r_seg);

    always_comb begin
        zero_cnt = 4'd0;
        an_idx   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!r_an[k]) begin
                zero_cnt = zero_cnt + 4'd1;
                an_idx   = IDX_W'(k);
            end
        end
        single = (zero_cnt == 4'd1);
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        ref_next   = ref_seg;
        idx_next   = idx;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (single) begin
                    state_next = TRACK;
                    ref_next   = r_seg;
                    idx_next   = an_idx;
                    cnt_next   = 8'd1;
                end
            end
            TRACK: begin
                if (!single) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else if (an_idx != idx) begin
                    idx_next = an_idx;
                    ref_next = r_seg;
                    cnt_next = 8'd1;
                end else if (r_seg != ref_seg) begin
                    ref_next = r_seg;
                    cnt_next = 8'd1;
                end else if (cnt >= 8'(STABLE_CYCLES - 1)) begin
                    capture    = 1'b1;
                    cnt_next   = 8'(STABLE_CYCLES);
                    state_next = HELD;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            HELD: begin
                // A changed anode is treated like a fresh arrival in IDLE.
                if (r_an != prev_an) begin
                    if (single) begin
                        state_next = TRACK;
                        ref_next   = r_seg;
                        idx_next   = an_idx;
                        cnt_next   = 8'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_done = &seen;
        seen_next  = frame_done ? '0 : seen;
        if (capture) seen_next[idx] = 1'b1;
        transfer = oFrameValid & iReady;
        load     = frame_done & (~oFrameValid | iReady);
        drop     = frame_done & oFrameValid & ~iReady;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_seg   <= '0;
            r_an    <= '0;
            prev_an <= '0;
            state   <= IDLE;
            ref_seg <= '0;
            idx     <= '0;
            cnt     <= '0;
            seen    <= '0;
        end else begin
            r_seg   <= iSeg;
            r_an    <= iAn;
            prev_an <= r_an;
            state   <= state_next;
            ref_seg <= ref_next;
            idx     <= idx_next;
            cnt     <= cnt_next;
            seen    <= seen_next;
        end
    end

    // NOTE: working registers are reset too, so a reset mid-frame leaves no stale digits behind.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            work_digits <= '0;
            work_blank  <= '0;
            work_err    <= '0;
        end else if (capture) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx == IDX_W'(k)) begin
                    work_digits[4*k +: 4] <= dec[3:0];
                    work_blank[k]         <= dec[5];
                    work_err[k]           <= dec[4];
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oFrameValid <= 1'b0;
            oDigits     <= '0;
            oBlank      <= '0;
            oErr        <= '0;
            oOverrun    <= 1'b0;
        end else begin
            if (load) begin
                oFrameValid <= 1'b1;
                oDigits     <= work_digits;
                oBlank      <= work_blank;
                oErr        <= work_err;
            end else if (transfer) begin
                oFrameValid <= 1'b0;
            end
            if (drop)          oOverrun <= 1'b1;
            else if (transfer) oOverrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader; expected frames go into a queue and a
// negedge monitor compares each frame the DUT hands over.
module tb_seg_scan_reader;

    localparam int DIGITS = 4;

    logic                iClk;
    logic                iRst_n;
    logic [6:0]          iSeg;
    logic [DIGITS-1:0]   iAn;
    logic                iReady;
    logic                oFrameValid;
    logic [4*DIGITS-1:0] oDigits;
    logic [DIGITS-1:0]   oBlank;
    logic [DIGITS-1:0]   oErr;
    logic                oOverrun;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  err;
    } frame_t;

    frame_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b1100000, S6B = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0001100, SA = 7'b0001000;
    localparam logic [6:0] SC = 7'b0110001, SD = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000;
    localparam logic [6:0] SBLANK = 7'b1111111, SBAD = 7'b1010101;

    seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iSeg        (iSeg),
        .iAn         (iAn),
        .iReady      (iReady),
        .oFrameValid (oFrameValid),
        .oDigits     (oDigits),
        .oBlank      (oBlank),
        .oErr        (oErr),
        .oOverrun    (oOverrun)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] b, input logic [3:0] e);
        frame_t f;
        f.digits = d;
        f.blank  = b;
        f.err    = e;
        exp_q.push_back(f);
    endtask

    // Drive digit k with pattern seg for n clocks; inputs change 1 time unit after a rising edge.
    task automatic scan(input int k, input logic [6:0] seg, input int n);
        logic [3:0] one;
        one  = 4'b0001;
        iAn  = ~(one << k);
        iSeg = seg;
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic idle_bus(input logic [3:0] an, input int n);
        iAn  = an;
        iSeg = S0;
        repeat (n) @(posedge iClk);
        #1;
    endtask

    always @(negedge iClk) begin
        if (iRst_n && oFrameValid && iReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got digits %0h, no frame expected", oDigits);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_digits", 32'(oDigits), 32'(f.digits));
                check("frame_blank",  32'(oBlank),  32'(f.blank));
                check("frame_err",    32'(oErr),    32'(f.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        iRst_n = 1'b0;
        iSeg   = SBLANK;
        iAn    = 4'b1111;
        iReady = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_valid",   32'(oFrameValid), 0);
        check("reset_digits",  32'(oDigits), 0);
        check("reset_overrun", 32'(oOverrun), 0);
        iRst_n = 1'b1;
        idle_bus(4'b1111, 2);

        // T1: basic frame
        push(16'hA321, 4'b0000, 4'b0000);
        scan(0, S1, 8); scan(1, S2, 8); scan(2, S3, 8); scan(3, SA, 8);
        check("t1_queue_drained", exp_q.size(), 0);
        check("t1_valid_pulse_ended", 32'(oFrameValid), 0);

        // T2: digit1 shown too briefly, frame withheld until it is rescanned
        scan(0, S1, 8); scan(1, S2, 2); scan(2, S3, 8); scan(3, SA, 8);
        check("t2_no_frame", 32'(oFrameValid), 0);
        push(16'hA321, 4'b0000, 4'b0000);
        scan(1, S2, 8);
        check("t2_queue_drained", exp_q.size(), 0);

        // T3: blank and undecodable digits
        push(16'hA001, 4'b0010, 4'b0100);
        scan(0, S1, 8); scan(1, SBLANK, 8); scan(2, SBAD, 8); scan(3, SA, 8);
        check("t3_queue_drained", exp_q.size(), 0);

        // T4: consumer stalled across two frames
        iReady = 1'b0;
        push(16'h6540, 4'b0000, 4'b0000);
        scan(0, S0, 8); scan(1, S4, 8); scan(2, S5, 8); scan(3, S6, 8);
        check("t4_first_valid",   32'(oFrameValid), 1);
        check("t4_first_digits",  32'(oDigits), 32'h6540);
        check("t4_first_overrun", 32'(oOverrun), 0);
        scan(0, S7, 8); scan(1, S8, 8); scan(2, S9, 8); scan(3, SC, 8);
        check("t4_held_valid",   32'(oFrameValid), 1);
        check("t4_held_digits",  32'(oDigits), 32'h6540);
        check("t4_overrun_set",  32'(oOverrun), 1);
        iAn    = 4'b1111;
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        check("t4_valid_cleared",   32'(oFrameValid), 0);
        check("t4_overrun_cleared", 32'(oOverrun), 0);
        check("t4_queue_drained",   exp_q.size(), 0);

        // T5: multi-anode and no-anode periods must not capture anything
        scan(0, SD, 8); scan(1, SE, 8);
        idle_bus(4'b1100, 20);
        idle_bus(4'b1111, 20);
        check("t5_no_frame", 32'(oFrameValid), 0);
        push(16'h6FED, 4'b0000, 4'b0000);
        scan(2, SF, 8); scan(3, S6B, 8);
        check("t5_queue_drained", exp_q.size(), 0);

        // T6: reset after half a frame
        scan(0, S1, 8); scan(1, S2, 8);
        iRst_n = 1'b0;
        #1;
        check("t6_reset_valid",   32'(oFrameValid), 0);
        check("t6_reset_digits",  32'(oDigits), 0);
        check("t6_reset_blank",   32'(oBlank), 0);
        check("t6_reset_err",     32'(oErr), 0);
        check("t6_reset_overrun", 32'(oOverrun), 0);
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        push(16'h0123, 4'b0000, 4'b0000);
        scan(2, S1, 8); scan(3, S0, 8); scan(0, S3, 8);
        check("t6_no_early_frame", 32'(oFrameValid), 0);
        iAn  = 4'b1101;
        iSeg = S2;
        repeat (5) @(posedge iClk);
        #1;
        check("t6_latency_not_yet", 32'(oFrameValid), 0);
        @(posedge iClk);
        #1;
        check("t6_latency_valid", 32'(oFrameValid), 1);
        repeat (3) @(posedge iClk);
        #1;
        check("t6_queue_drained", exp_q.size(), 0);
        check("t6_valid_dropped", 32'(oFrameValid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
